cacheline_arbiter: RTL and testbench

Arbitrates a single physical-memory cacheline port between the instruction cache (read-only) and the data cache (read/write) of the mp3 core. Sits between the two cache pmem ports and the cacheline adaptor. It services one transaction at a time, alternates fairly under contention, registers all downstream request signals, and routes the response to the owner. Saturating grant counters are exported for performance debug.

---
 rtl/cacheline_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_cacheline_arbiter.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_arbiter.sv
// ============================================================================
// cacheline_arbiter
// ----------------------------------------------------------------------------
// Shares one physical-memory cacheline port between the instruction cache
// (read-only) and the data cache (read/write). One transaction is in flight
// at a time. When both caches request together, the grant goes to the side
// that did not win last time. All downstream request signals come from
// registers. The response is routed back to whichever side owns the
// transaction. Saturating per-requester grant counters are exported for
// performance debug.
//
// Parameters
//    LINE_W : cacheline width in bits
//    ADDR_W : address width in bits
//    CNT_W  : width of each grant counter
//
// Ports
//    clk, rst          : clock; asynchronous active-low reset
//    i_read, i_addr    : I-cache line read request (held until i_resp)
//    i_rdata, i_resp   : I-cache read data and one-cycle completion pulse
//    d_read, d_write   : D-cache line read/write request (held until d_resp)
//    d_addr, d_wdata   : D-cache line address and write line
//    d_rdata, d_resp   : D-cache read data and one-cycle completion pulse
//    pmem_read/write   : registered downstream request
//    pmem_address      : registered line-aligned address
//    pmem_wdata        : registered write line
//    pmem_rdata, resp  : downstream read data and completion pulse
//    i_grants/d_grants : saturating grant counters
// ============================================================================
module cacheline_arbiter #(
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   // I-cache side
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   // D-cache side
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   // Downstream cacheline adaptor side
   output logic              pmem_read,
   output logic              pmem_write,
   output logic [ADDR_W-1:0] pmem_address,
   output logic [LINE_W-1:0] pmem_wdata,
   input  logic [LINE_W-1:0] pmem_rdata,
   input  logic              pmem_resp,
   // Performance debug
   output logic [CNT_W-1:0]  i_grants,
   output logic [CNT_W-1:0]  d_grants
);

   // Number of byte-offset bits within one cacheline.
   localparam int OFFS_W = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_SERVE_I = 2'd1,
      ST_SERVE_D = 2'd2
   } state_t;

   state_t            state_r;
   logic              last_grant_d_r;   // 1: most recent grant went to the D-cache
   logic              pmem_read_r;
   logic              pmem_write_r;
   logic [ADDR_W-1:0] pmem_address_r;
   logic [LINE_W-1:0] pmem_wdata_r;
   logic [CNT_W-1:0]  i_grants_r;
   logic [CNT_W-1:0]  d_grants_r;

   logic              pending_i_s;
   logic              pending_d_s;
   logic              grant_i_s;
   logic              grant_d_s;

   // Clears the byte-offset bits so the downstream port always sees a
   // line-aligned address.
   function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] mask;
      mask = {ADDR_W{1'b1}} << OFFS_W;
      return addr & mask;
   endfunction

   // Adds one to a counter, but holds it once it reaches all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
      logic [CNT_W-1:0] result;
      if (value == {CNT_W{1'b1}}) begin
         result = value;
      end else begin
         result = value + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return result;
   endfunction

   // Grant decision: grants are made only from IDLE. Under a tie, the side
   // that was not granted last time wins.
   always_comb begin
      pending_i_s = i_read;
      pending_d_s = d_read | d_write;
      grant_i_s   = 1'b0;
      grant_d_s   = 1'b0;
      if (state_r == ST_IDLE) begin
         if (pending_i_s && pending_d_s) begin
            if (last_grant_d_r) begin
               grant_i_s = 1'b1;
            end else begin
               grant_d_s = 1'b1;
            end
         end else if (pending_i_s) begin
            grant_i_s = 1'b1;
         end else if (pending_d_s) begin
            grant_d_s = 1'b1;
         end else begin
            grant_i_s = 1'b0;
            grant_d_s = 1'b0;
         end
      end else begin
         grant_i_s = 1'b0;
         grant_d_s = 1'b0;
      end
   end

   // Arbiter FSM: latches the winning request into the pmem registers,
   // keeps them stable while the transaction runs, and returns to IDLE on
   // the downstream response.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r        <= ST_IDLE;
         last_grant_d_r <= 1'b1;           // first tie after reset goes to I
         pmem_read_r    <= 1'b0;
         pmem_write_r   <= 1'b0;
         pmem_address_r <= {ADDR_W{1'b0}};
         pmem_wdata_r   <= {LINE_W{1'b0}};
         i_grants_r     <= {CNT_W{1'b0}};
         d_grants_r     <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (grant_i_s) begin
                  pmem_read_r    <= 1'b1;
                  pmem_write_r   <= 1'b0;
                  pmem_address_r <= align_addr(i_addr);
                  pmem_wdata_r   <= {LINE_W{1'b0}};
                  last_grant_d_r <= 1'b0;
                  i_grants_r     <= sat_inc(i_grants_r);
                  state_r        <= ST_SERVE_I;
               end else if (grant_d_s) begin
                  // A simultaneous read and write is treated as a write.
                  pmem_read_r    <= ~d_write;
                  pmem_write_r   <= d_write;
                  pmem_address_r <= align_addr(d_addr);
                  pmem_wdata_r   <= d_wdata;
                  last_grant_d_r <= 1'b1;
                  d_grants_r     <= sat_inc(d_grants_r);
                  state_r        <= ST_SERVE_D;
               end else begin
                  // A stray pmem_resp while idle is ignored.
                  state_r        <= ST_IDLE;
               end
            end
            ST_SERVE_I,
            ST_SERVE_D: begin
               if (pmem_resp) begin
                  pmem_read_r  <= 1'b0;
                  pmem_write_r <= 1'b0;
                  state_r      <= ST_IDLE;
               end else begin
                  state_r      <= state_r;
               end
            end
            default: begin
               pmem_read_r  <= 1'b0;
               pmem_write_r <= 1'b0;
               state_r      <= ST_IDLE;
            end
         endcase
      end
   end

   // The response is combinational so the owner sees it in the same cycle
   // as pmem_resp. Read data is broadcast and qualified by the resp pulses.
   assign i_resp       = pmem_resp & (state_r == ST_SERVE_I);
   assign d_resp       = pmem_resp & (state_r == ST_SERVE_D);
   assign i_rdata      = pmem_rdata;
   assign d_rdata      = pmem_rdata;

   assign pmem_read    = pmem_read_r;
   assign pmem_write   = pmem_write_r;
   assign pmem_address = pmem_address_r;
   assign pmem_wdata   = pmem_wdata_r;
   assign i_grants     = i_grants_r;
   assign d_grants     = d_grants_r;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// ============================================================================
// tb_cacheline_arbiter
// ----------------------------------------------------------------------------
// Directed self-checking bench. Two instances share all inputs: u_dut uses
// the default 16-bit counters, and u_sat uses 2-bit counters to exercise
// saturation. Inputs change #1 after a rising edge. Outputs are compared
// after a further #1 settle.
// ============================================================================
module tb_cacheline_arbiter;

   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;

   logic              clk;
   logic              rst;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] pmem_rdata;
   logic              pmem_resp;

   logic [LINE_W-1:0] i_rdata, d_rdata, pmem_wdata;
   logic              i_resp, d_resp, pmem_read, pmem_write;
   logic [ADDR_W-1:0] pmem_address;
   logic [15:0]       i_grants, d_grants;

   logic [LINE_W-1:0] s_i_rdata, s_d_rdata, s_pmem_wdata;
   logic              s_i_resp, s_d_resp, s_pmem_read, s_pmem_write;
   logic [ADDR_W-1:0] s_pmem_address;
   logic [1:0]        s_i_grants, s_d_grants;

   int n_tests;
   int n_fail;

   cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(16)) u_dut (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
      .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .i_grants(i_grants), .d_grants(d_grants)
   );

   cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst),
      .i_read(i_read), .i_addr(i_addr), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_rdata(s_d_rdata), .d_resp(s_d_resp),
      .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_address(s_pmem_address),
      .pmem_wdata(s_pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
      .i_grants(s_i_grants), .d_grants(s_d_grants)
   );

   // Free-running clock, 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      i_read     = 1'b0;
      i_addr     = 32'h0000_0000;
      d_read     = 1'b0;
      d_write    = 1'b0;
      d_addr     = 32'h0000_0000;
      d_wdata    = {LINE_W{1'b0}};
      pmem_rdata = {LINE_W{1'b0}};
      pmem_resp  = 1'b0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         n_fail++; $display("FAIL reset_req: rd=%b wr=%b expected 0 0", pmem_read, pmem_write);
      end
      n_tests++;
      if (pmem_address !== 32'h0 || pmem_wdata !== {LINE_W{1'b0}}) begin
         n_fail++; $display("FAIL reset_data: addr=%h expected 0", pmem_address);
      end
      n_tests++;
      if (i_grants !== 16'd0 || d_grants !== 16'd0) begin
         n_fail++; $display("FAIL reset_cnt: i=%0d d=%0d expected 0 0", i_grants, d_grants);
      end
      n_tests++;
      if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
         n_fail++; $display("FAIL reset_resp: i=%b d=%b expected 0 0", i_resp, d_resp);
      end
      pmem_resp = 1'b0;
   endtask

   task automatic test_single_i_read();
      logic [LINE_W-1:0] pat;
      pat = {32{8'hA5}};
      do_reset();
      i_read = 1'b1;
      i_addr = 32'h0000_0064;
      tick();                                     // cycle 1
      n_tests++;
      if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 32'h0000_0060) begin
         n_fail++; $display("FAIL i_read_req: rd=%b wr=%b addr=%h expected 1 0 00000060",
                            pmem_read, pmem_write, pmem_address);
      end
      repeat (4) tick();                          // cycle 5
      pmem_rdata = pat;
      pmem_resp  = 1'b1;
      #1;
      n_tests++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== pat) begin
         n_fail++; $display("FAIL i_read_resp: i_resp=%b d_resp=%b rdata_lsw=%h expected 1 0 a5a5a5a5",
                            i_resp, d_resp, i_rdata[31:0]);
      end
      tick();                                     // cycle 6
      pmem_resp = 1'b0;
      i_read    = 1'b0;
      #1;
      n_tests++;
      if (pmem_read !== 1'b0 || i_grants !== 16'd1 || d_grants !== 16'd0) begin
         n_fail++; $display("FAIL i_read_done: rd=%b i_grants=%0d d_grants=%0d expected 0 1 0",
                            pmem_read, i_grants, d_grants);
      end
   endtask

   task automatic test_single_d_write();
      logic [LINE_W-1:0] wd;
      wd = {8{32'hDEAD_BEEF}};
      do_reset();
      d_write = 1'b1;
      d_addr  = 32'h0000_1000;
      d_wdata = wd;
      tick();
      d_wdata = {LINE_W{1'b0}};                   // ignored while serving
      #1;
      n_tests++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_1000 || pmem_wdata !== wd) begin
         n_fail++; $display("FAIL d_write_req: wr=%b rd=%b addr=%h wd_lsw=%h expected 1 0 00001000 deadbeef",
                            pmem_write, pmem_read, pmem_address, pmem_wdata[31:0]);
      end
      tick();
      n_tests++;
      if (d_resp !== 1'b0) begin
         n_fail++; $display("FAIL d_write_early: d_resp=%b expected 0", d_resp);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         n_fail++; $display("FAIL d_write_resp: d_resp=%b i_resp=%b expected 1 0", d_resp, i_resp);
      end
      tick();
      pmem_resp = 1'b0;
      d_write   = 1'b0;
      #1;
      n_tests++;
      if (pmem_write !== 1'b0 || d_grants !== 16'd1 || i_grants !== 16'd0) begin
         n_fail++; $display("FAIL d_write_done: wr=%b d_grants=%0d i_grants=%0d expected 0 1 0",
                            pmem_write, d_grants, i_grants);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      i_read = 1'b1; i_addr = 32'h0000_0100;
      d_read = 1'b1; d_addr = 32'h0000_0200;
      tick();
      n_tests++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0100) begin
         n_fail++; $display("FAIL sim_first: rd=%b addr=%h expected 1 00000100", pmem_read, pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if (i_resp !== 1'b1 || d_resp !== 1'b0) begin
         n_fail++; $display("FAIL sim_first_resp: i=%b d=%b expected 1 0", i_resp, d_resp);
      end
      tick();                                     // idle bubble
      pmem_resp = 1'b0;
      i_read    = 1'b0;
      #1;
      n_tests++;
      if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
         n_fail++; $display("FAIL sim_bubble: rd=%b wr=%b expected 0 0", pmem_read, pmem_write);
      end
      tick();
      n_tests++;
      if (pmem_read !== 1'b1 || pmem_address !== 32'h0000_0200) begin
         n_fail++; $display("FAIL sim_second: rd=%b addr=%h expected 1 00000200", pmem_read, pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
         n_fail++; $display("FAIL sim_second_resp: d=%b i=%b expected 1 0", d_resp, i_resp);
      end
      tick();
      pmem_resp = 1'b0;
      d_read    = 1'b0;
      #1;
      n_tests++;
      if (i_grants !== 16'd1 || d_grants !== 16'd1 || pmem_read !== 1'b0) begin
         n_fail++; $display("FAIL sim_counts: i=%0d d=%0d rd=%b expected 1 1 0", i_grants, d_grants, pmem_read);
      end
   endtask

   task automatic test_back_to_back();
      logic [ADDR_W-1:0] exp_addr;
      logic              exp_i;
      do_reset();
      i_read = 1'b1;
      d_read = 1'b1;
      for (int k = 0; k < 6; k++) begin
         i_addr   = 32'h0000_1004 + 32'(k) * 32'd64;
         d_addr   = 32'h0000_2008 + 32'(k) * 32'd64;
         exp_i    = ((k % 2) == 0);
         exp_addr = exp_i ? (32'h0000_1000 + 32'(k) * 32'd64) : (32'h0000_2000 + 32'(k) * 32'd64);
         tick();
         n_tests++;
         if (pmem_read !== 1'b1 || pmem_address !== exp_addr) begin
            n_fail++; $display("FAIL b2b_grant[%0d]: rd=%b addr=%h expected 1 %h", k, pmem_read, pmem_address, exp_addr);
         end
         i_addr = 32'hFFFF_FFE0;                  // mid-serve changes are ignored
         d_addr = 32'hFFFF_FFE0;
         tick();
         n_tests++;
         if (pmem_address !== exp_addr) begin
            n_fail++; $display("FAIL b2b_hold[%0d]: addr=%h expected %h", k, pmem_address, exp_addr);
         end
         pmem_resp = 1'b1;
         #1;
         n_tests++;
         if (i_resp !== exp_i || d_resp !== !exp_i) begin
            n_fail++; $display("FAIL b2b_resp[%0d]: i=%b d=%b expected %b %b", k, i_resp, d_resp, exp_i, !exp_i);
         end
         tick();
         pmem_resp = 1'b0;
         #1;
         n_tests++;
         if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
            n_fail++; $display("FAIL b2b_idle[%0d]: rd=%b wr=%b expected 0 0", k, pmem_read, pmem_write);
         end
      end
      i_read = 1'b0;
      d_read = 1'b0;
      n_tests++;
      if (i_grants !== 16'd3 || d_grants !== 16'd3) begin
         n_fail++; $display("FAIL b2b_counts: i=%0d d=%0d expected 3 3", i_grants, d_grants);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      d_write = 1'b1;
      d_addr  = 32'h0000_3000;
      d_wdata = {8{32'h1234_5678}};
      tick();
      n_tests++;
      if (pmem_write !== 1'b1 || d_grants !== 16'd1) begin
         n_fail++; $display("FAIL rstmid_pre: wr=%b d_grants=%0d expected 1 1", pmem_write, d_grants);
      end
      #2;
      rst     = 1'b0;                             // between edges
      d_write = 1'b0;
      #1;
      n_tests++;
      if (pmem_write !== 1'b0 || d_grants !== 16'd0 || pmem_address !== 32'h0) begin
         n_fail++; $display("FAIL rstmid_async: wr=%b d_grants=%0d addr=%h expected 0 0 0",
                            pmem_write, d_grants, pmem_address);
      end
      tick();
      rst       = 1'b1;
      pmem_resp = 1'b1;                           // late response, no owner
      #1;
      n_tests++;
      if (d_resp !== 1'b0 || i_resp !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_resp: d=%b i=%b expected 0 0", d_resp, i_resp);
      end
      tick();
      pmem_resp = 1'b0;
      #1;
      n_tests++;
      if (pmem_write !== 1'b0 || pmem_read !== 1'b0 || d_grants !== 16'd0) begin
         n_fail++; $display("FAIL rstmid_idle: wr=%b rd=%b d_grants=%0d expected 0 0 0",
                            pmem_write, pmem_read, d_grants);
      end
   endtask

   task automatic test_saturation();
      do_reset();
      for (int k = 0; k < 5; k++) begin
         i_read = 1'b1;
         i_addr = 32'h0000_4000 + 32'(k) * 32'd32;
         tick();
         pmem_resp = 1'b1;
         #1;
         n_tests++;
         if (i_resp !== 1'b1 || s_i_resp !== 1'b1) begin
            n_fail++; $display("FAIL sat_resp[%0d]: i=%b s_i=%b expected 1 1", k, i_resp, s_i_resp);
         end
         tick();
         pmem_resp = 1'b0;
         i_read    = 1'b0;
      end
      tick();
      n_tests++;
      if (s_i_grants !== 2'd3 || i_grants !== 16'd5) begin
         n_fail++; $display("FAIL sat_count: small=%0d wide=%0d expected 3 5", s_i_grants, i_grants);
      end
      d_read  = 1'b1;
      d_write = 1'b1;
      d_addr  = 32'h0000_5010;
      tick();
      n_tests++;
      if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_address !== 32'h0000_5000) begin
         n_fail++; $display("FAIL rw_tie: wr=%b rd=%b addr=%h expected 1 0 00005000",
                            pmem_write, pmem_read, pmem_address);
      end
      pmem_resp = 1'b1;
      #1;
      n_tests++;
      if (d_resp !== 1'b1) begin
         n_fail++; $display("FAIL rw_tie_resp: d=%b expected 1", d_resp);
      end
      tick();
      pmem_resp = 1'b0;
      d_read    = 1'b0;
      d_write   = 1'b0;
      #1;
      n_tests++;
      if (pmem_write !== 1'b0 || s_d_grants !== 2'd1) begin
         n_fail++; $display("FAIL rw_tie_done: wr=%b s_d_grants=%0d expected 0 1", pmem_write, s_d_grants);
      end
   endtask

   // Test sequence.
   initial begin
      n_tests = 0;
      n_fail  = 0;
      rst     = 1'b0;
      idle_inputs();
      test_reset();
      test_single_i_read();
      test_single_d_write();
      test_simultaneous();
      test_back_to_back();
      test_reset_mid();
      test_saturation();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
